// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, default sizes and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int UART_DEFAULT_OVERSAMPLE = 16;
  localparam int UART_DEFAULT_DATA_BITS  = 8;
  localparam int UART_MAX_BITS           = 16;
  // Expected parity bit: XOR of data, inverted for odd parity
  function automatic logic uart_parity(input logic [UART_MAX_BITS-1:0] i_d, input logic i_odd);
    return (^i_d) ^ i_odd;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser with configurable reset value
module uart_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  assign o_q = r_q;
  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with valid/ready output; UART_RX_PARITY_EN adds a parity bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic                 I_sample_clk,
  input  logic                 I_rx,
  output logic [DATA_BITS-1:0] O_data,
  output logic                 O_valid,
  input  logic                 I_ready,
  output logic                 O_frame_error,
  output logic                 O_parity_error,
  output logic                 O_overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  logic w_rx, w_sclk, w_tick, w_fall;
  logic r_rx_prev, r_sclk_prev;
  uart_state_e r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt, w_tick_nxt;
  logic [BW-1:0] r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic w_good, w_ferr;
  logic r_valid, r_ferr, r_ovr;
  logic [DATA_BITS-1:0] r_data;

  uart_sync #(.RST_VAL(1'b1)) u_sync_rx (
    .i_clk(I_clk), .i_reset_n(I_reset_n), .i_d(I_rx), .o_q(w_rx)
  );
  uart_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(I_clk), .i_reset_n(I_reset_n), .i_d(I_sample_clk), .o_q(w_sclk)
  );

  assign w_tick = w_sclk & ~r_sclk_prev;
  assign w_fall = r_rx_prev & ~w_rx;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, w_par_bad_nxt, w_perr, r_perr;
  assign O_parity_error = r_perr;
`else
  assign O_parity_error = 1'b0;
`endif

  // Next-state, counters, shifter and frame verdict
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr        = 1'b0;
`endif
    case (r_state)
      IDLE: if (w_fall) begin
        w_state_nxt = START;
        w_tick_nxt  = '0;
      end
      START: if (w_tick) begin
        w_tick_nxt = r_tick_cnt + 1'b1;
        if (r_tick_cnt == HALF) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? IDLE : DATA;
        end
      end
      DATA: if (w_tick) begin
        w_tick_nxt = r_tick_cnt + 1'b1;
        if (r_tick_cnt == FULL) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
          w_bit_nxt   = r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST) begin
            w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_tick) begin
        w_tick_nxt = r_tick_cnt + 1'b1;
        if (r_tick_cnt == FULL) begin
          w_tick_nxt    = '0;
          w_par_bad_nxt = w_rx ^ uart_parity(UART_MAX_BITS'(r_shift), PARITY_ODD);
          w_state_nxt   = STOP;
        end
      end
`endif
      STOP: if (w_tick) begin
        w_tick_nxt = r_tick_cnt + 1'b1;
        if (r_tick_cnt == FULL) begin
          w_tick_nxt  = '0;
          w_state_nxt = IDLE;
          w_ferr      = ~w_rx;
`ifdef UART_RX_PARITY_EN
          w_perr = w_rx & r_par_bad;
          w_good = w_rx & ~r_par_bad;
`else
          w_good = w_rx;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge-detect history, FSM state and receive datapath
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_rx_prev   <= 1'b1;
      r_sclk_prev <= 1'b0;
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= 1'b0;
`endif
    end else begin
      r_rx_prev   <= w_rx;
      r_sclk_prev <= w_sclk;
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= w_par_bad_nxt;
`endif
    end
  end

  // Output register: deliver, flag overrun, or clear on handshake
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_good & r_valid & ~I_ready;
`ifdef UART_RX_PARITY_EN
      r_perr <= w_perr;
`endif
      if (w_good && (!r_valid || I_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (I_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign O_data        = r_data;
  assign O_valid       = r_valid;
  assign O_frame_error = r_ferr;
  assign O_overrun     = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
  localparam int BIT = 64;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int LAT_NOM = (FBITS - 1) * BIT + 36;

  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, ready = 1'b0;
  logic sclk;
  logic [1:0] ph = 2'd0;
  logic [7:0] data;
  logic valid, ferr, perr, ovr;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  always @(posedge clk) cyc <= cyc + 1;
  assign sclk = ph[1];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(PODD)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_sample_clk(sclk), .I_rx(rx),
    .O_data(data), .O_valid(valid), .I_ready(ready),
    .O_frame_error(ferr), .O_parity_error(perr), .O_overrun(ovr)
  );

  int total = 0, bad = 0;
  int fe_cnt = 0, pe_cnt = 0, ovr_cnt = 0, t_rise = 0, lat = LAT_NOM;
  logic valid_q = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int exp_fe = 0, exp_pe = 0, exp_ovr = 0;

  always @(negedge clk) begin
    if (ferr === 1'b1) fe_cnt++;
    if (perr === 1'b1) pe_cnt++;
    if (ovr === 1'b1) ovr_cnt++;
    if (valid === 1'b1 && !valid_q) t_rise = cyc;
    valid_q = (valid === 1'b1);
    if (valid === 1'b1 && ready) got_q.push_back(data);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    while (ph != 2'd0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok, input bit tail, output int t0);
    align();
    t0 = cyc;
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ PODD ^ !par_ok;
    wait_cyc(BIT);
`endif
    rx = stop;
    wait_cyc(BIT);
    rx = tail;
    wait_cyc(16);
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop, input bit par_ok, input bit r);
    bit good;
`ifdef UART_RX_PARITY_EN
    good = stop && par_ok;
    if (stop && !par_ok) exp_pe++;
`else
    good = stop;
`endif
    if (r && m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
    if (!stop) exp_fe++;
    else if (good) begin
      if (m_valid) exp_ovr++;
      else if (r) exp_q.push_back(d);
      else begin
        m_valid = 1'b1;
        m_data = d;
      end
    end
  endtask

  task automatic accept();
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    wait_cyc(1);
    if (m_valid) exp_q.push_back(m_data);
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
    total++; if (ferr !== 1'b0 || perr !== 1'b0 || ovr !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b%b want=000", ferr, perr, ovr); end
    rst_n = 1'b1;
    wait_cyc(8);
  endtask

  task automatic test_byte();
    int t0;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    lat = t_rise - t0;
    total++; if (lat < LAT_NOM - 8 || lat > LAT_NOM + 8) begin bad++; $display("FAIL byte_latency got=%0d want=%0d+-8", lat, LAT_NOM); end
    if (lat < 1 || lat > 4 * LAT_NOM) lat = LAT_NOM;
    total++; if (valid !== m_valid) begin bad++; $display("FAIL byte_valid got=%b want=%b", valid, m_valid); end
    total++; if (data !== m_data) begin bad++; $display("FAIL byte_data got=%h want=%h", data, m_data); end
    total++; if (fe_cnt !== exp_fe || ovr_cnt !== exp_ovr) begin bad++; $display("FAIL byte_errs got=%0d/%0d want=%0d/%0d", fe_cnt, ovr_cnt, exp_fe, exp_ovr); end
    accept();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL byte_handshake got=%b want=0", valid); end
  endtask

  task automatic test_glitch();
    align();
    rx = 1'b0;
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(200);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", valid); end
    total++; if (fe_cnt !== exp_fe || pe_cnt !== exp_pe) begin bad++; $display("FAIL glitch_errs got=%0d/%0d want=%0d/%0d", fe_cnt, pe_cnt, exp_fe, exp_pe); end
  endtask

  task automatic test_break();
    int t0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, t0);
    model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_cyc(5 * BIT);
    total++; if (fe_cnt !== exp_fe) begin bad++; $display("FAIL break_fe got=%0d want=%0d", fe_cnt, exp_fe); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL break_valid got=%b want=0", valid); end
    rx = 1'b1;
    wait_cyc(32);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    total++; if (valid !== 1'b1 || data !== 8'h5A) begin bad++; $display("FAIL break_recover got=%b/%h want=1/5a", valid, data); end
    total++; if (fe_cnt !== exp_fe) begin bad++; $display("FAIL break_fe_once got=%0d want=%0d", fe_cnt, exp_fe); end
    accept();
  endtask

  task automatic test_overrun();
    int t0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'h22, 1'b1, 1'b1, 1'b0);
    total++; if (data !== 8'h11 || valid !== 1'b1) begin bad++; $display("FAIL ovr_data got=%b/%h want=1/11", valid, data); end
    total++; if (ovr_cnt !== exp_ovr) begin bad++; $display("FAIL ovr_pulse got=%0d want=%0d", ovr_cnt, exp_ovr); end
    accept();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", valid); end
    total++; if ((got_q.size() > 0 ? got_q[$] : 8'hXX) !== 8'h11) begin bad++; $display("FAIL ovr_taken got=%h want=11", got_q.size() > 0 ? got_q[$] : 8'hXX); end
  endtask

  task automatic test_simul();
    int t0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'h11, 1'b1, 1'b1, 1'b0);
    align();
    fork
      send_frame(8'h22, 1'b1, 1'b1, 1'b1, t0);
      begin
        wait_cyc(lat - 1);
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
      end
    join
    exp_q.push_back(8'h11);
    m_data = 8'h22;
    m_valid = 1'b1;
    total++; if (data !== 8'h22 || valid !== 1'b1) begin bad++; $display("FAIL simul_data got=%b/%h want=1/22", valid, data); end
    total++; if (ovr_cnt !== exp_ovr) begin bad++; $display("FAIL simul_ovr got=%0d want=%0d", ovr_cnt, exp_ovr); end
    total++; if ((got_q.size() > 0 ? got_q[$] : 8'hXX) !== 8'h11) begin bad++; $display("FAIL simul_taken got=%h want=11", got_q.size() > 0 ? got_q[$] : 8'hXX); end
    accept();
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] d;
    send_frame(8'h33, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'h33, 1'b1, 1'b1, 1'b0);
    d = 8'hF0;
    align();
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_cyc(BIT);
    end
    rx = d[4];
    wait_cyc(32);
    rst_n = 1'b0;
    #1;
    total++; if (valid !== 1'b0 || data !== 8'h00) begin bad++; $display("FAIL rstmid_out got=%b/%h want=0/00", valid, data); end
    m_valid = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    rx = 1'b1;
    wait_cyc(5 * BIT);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_partial got=%b want=0", valid); end
    send_frame(8'h96, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'h96, 1'b1, 1'b1, 1'b0);
    total++; if (valid !== 1'b1 || data !== 8'h96) begin bad++; $display("FAIL rstmid_after got=%b/%h want=1/96", valid, data); end
    accept();
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int t0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, t0);
    model_frame(8'h07, 1'b1, 1'b0, 1'b0);
    total++; if (pe_cnt !== exp_pe) begin bad++; $display("FAIL parity_pulse got=%0d want=%0d", pe_cnt, exp_pe); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL parity_valid got=%b want=0", valid); end
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, t0);
    model_frame(8'h07, 1'b1, 1'b1, 1'b0);
    total++; if (valid !== 1'b1 || data !== 8'h07) begin bad++; $display("FAIL parity_good got=%b/%h want=1/07", valid, data); end
    accept();
`else
    total++; if (pe_cnt !== 0) begin bad++; $display("FAIL parity_tied got=%0d want=0", pe_cnt); end
`endif
  endtask

  task automatic test_random();
    int t0;
    logic [7:0] d;
    bit stop, par_ok, r;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par_ok = ($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      ready = r;
      send_frame(d, stop, par_ok, 1'b1, t0);
      model_frame(d, stop, par_ok, r);
      ready = 1'b0;
      wait_cyc(2);
      total++; if (valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d] got=%b want=%b", n, valid, m_valid); end
      if (m_valid) begin
        total++; if (data !== m_data) begin bad++; $display("FAIL rand_data[%0d] got=%h want=%h", n, data, m_data); end
      end
    end
    accept();
    total++; if (fe_cnt !== exp_fe || pe_cnt !== exp_pe || ovr_cnt !== exp_ovr) begin bad++; $display("FAIL rand_errs got=%0d/%0d/%0d want=%0d/%0d/%0d", fe_cnt, pe_cnt, ovr_cnt, exp_fe, exp_pe, exp_ovr); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL sb_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sb_byte[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_glitch();
    test_break();
    test_overrun();
    test_simul();
    test_reset_mid();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
